// File: rtl/gb_instr_issuer.sv
// gb_instr_issuer: buffers host opcodes in a small FIFO, issues them to the
// processor as one-cycle strobes with an optional idle gap between issues,
// and captures the processor probe a fixed number of cycles after each issue.
module gb_instr_issuer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned GAP       = 0,
  parameter int unsigned PROBE_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] host_instr,
  input  logic       host_valid,
  output logic       host_ready,
  output logic [7:0] instruction,
  output logic       valid,
  input  logic [7:0] probe,
  output logic [7:0] probe_out,
  output logic       probe_valid,
  output logic [7:0] issued_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_GAPWAIT = 2'd2
  } state_t;

  logic [7:0]           mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 host_ready_q, host_ready_d;
  state_t               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 valid_q, valid_d;
  logic [7:0]           instr_q, instr_d;
  logic [7:0]           issued_q, issued_d;
  logic [PROBE_LAT-1:0] pipe_q, pipe_d;
  logic [7:0]           probe_out_q, probe_out_d;
  logic                 probe_valid_q, probe_valid_d;

  logic push;
  logic pop;
  logic not_empty;

  // FIFO bookkeeping and issue FSM next-state / registered-output logic
  always_comb begin
    pop          = 1'b0;
    state_d      = state_q;
    gap_d        = gap_q;
    valid_d      = 1'b0;
    instr_d      = 8'h00;
    push         = host_valid && host_ready_q;
    not_empty    = (count_q != '0);

    unique case (state_q)
      S_IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          valid_d = 1'b1;
          instr_d = mem_q[rd_ptr_q];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (GAP > 0) begin
          state_d = S_GAPWAIT;
          gap_d   = GAP_W'(GAP - 1);
        end else if (not_empty) begin
          pop     = 1'b1;
          valid_d = 1'b1;
          instr_d = mem_q[rd_ptr_q];
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAPWAIT: begin
        if (gap_q == '0) begin
          if (not_empty) begin
            pop     = 1'b1;
            valid_d = 1'b1;
            instr_d = mem_q[rd_ptr_q];
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    host_ready_d = (count_d != CNT_W'(DEPTH));
    issued_d     = valid_d ? issued_q + 8'd1 : issued_q;
  end

  // Probe capture pipeline: the oldest stage marks the edge to sample probe
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = valid_d;
    for (int unsigned i = 1; i < PROBE_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    probe_valid_d = pipe_q[PROBE_LAT-1];
    probe_out_d   = pipe_q[PROBE_LAT-1] ? probe : probe_out_q;
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= host_instr;
    end
  end

  // Control and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      host_ready_q  <= 1'b0;
      state_q       <= S_IDLE;
      gap_q         <= '0;
      valid_q       <= 1'b0;
      instr_q       <= 8'h00;
      issued_q      <= 8'h00;
      pipe_q        <= '0;
      probe_out_q   <= 8'h00;
      probe_valid_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      host_ready_q  <= host_ready_d;
      state_q       <= state_d;
      gap_q         <= gap_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      issued_q      <= issued_d;
      pipe_q        <= pipe_d;
      probe_out_q   <= probe_out_d;
      probe_valid_q <= probe_valid_d;
    end
  end

  assign host_ready   = host_ready_q;
  assign instruction  = instr_q;
  assign valid        = valid_q;
  assign probe_out    = probe_out_q;
  assign probe_valid  = probe_valid_q;
  assign issued_count = issued_q;

endmodule
